// File: rtl/uart_transmitter.sv
// UART transmit half: frames a parallel word as start, LSB-first data, optional
// parity and stop, paced by the shared oversampling Tick strobe.
module uart_transmitter #(
  parameter int DATA_BITS      = 8,
  parameter int TICKS_PER_BIT  = 16,
  parameter int STOP_BIT_TICKS = 16,
  parameter int PARITY         = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 Tx,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [5:0] BIT_END  = 6'(TICKS_PER_BIT - 1);
  localparam logic [5:0] STOP_END = 6'(STOP_BIT_TICKS - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       ODD      = (PARITY == 2);

  logic [2:0]           state;
  logic [5:0]           tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc;
  logic                 par_bit;

  // Parity over all data bits, including the one leaving the shifter this tick.
  assign par_bit = par_acc ^ shift[0] ^ ODD;
  assign TxBusy  = (state != S_IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_acc  <= 1'b0;
      Tx       <= 1'b1;
      TxDone   <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      case (state)
        S_IDLE: begin
          Tx <= 1'b1;
          if (TxStart) begin
            shift    <= TxData;
            tick_cnt <= '0;
            par_acc  <= 1'b0;
            state    <= S_START;
            Tx       <= 1'b0;
          end
        end
        S_START: if (Tick) begin
          if (tick_cnt == BIT_END) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
            Tx       <= shift[0];
          end else tick_cnt <= tick_cnt + 6'd1;
        end
        S_DATA: if (Tick) begin
          if (tick_cnt == BIT_END) begin
            tick_cnt <= '0;
            par_acc  <= par_acc ^ shift[0];
            shift    <= shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              if (PARITY != 0) begin
                state <= S_PAR;
                Tx    <= par_bit;
              end else begin
                state <= S_STOP;
                Tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              Tx      <= shift[1];
            end
          end else tick_cnt <= tick_cnt + 6'd1;
        end
        S_PAR: if (Tick) begin
          if (tick_cnt == BIT_END) begin
            tick_cnt <= '0;
            state    <= S_STOP;
            Tx       <= 1'b1;
          end else tick_cnt <= tick_cnt + 6'd1;
        end
        S_STOP: begin
          Tx <= 1'b1;
          if (Tick) begin
            if (tick_cnt == STOP_END) begin
              tick_cnt <= '0;
              state    <= S_IDLE;
              TxDone   <= 1'b1;
            end else tick_cnt <= tick_cnt + 6'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four differently configured instances, a line
// sampler per instance, and a frame scoreboard fed by the stimulus process.
module tb_uart_transmitter;
  localparam int N   = 4;
  localparam int TPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic tick_en = 1'b1;
  logic [N-1:0] start = '0;
  logic [N-1:0] tx, busy, done;
  logic [N-1:0][7:0] data = '0;

  logic [7:0] exp_q[N][$];
  bit         samp[N][$];
  int sent[N];
  int done_cnt[N];
  bit prev_done[N];
  int tests_a = 0, fails_a = 0, tests_m = 0, fails_m = 0;

  function automatic int db_of(int i);
    return (i == 3) ? 6 : 8;
  endfunction
  function automatic int par_of(int i);
    return (i == 1) ? 1 : (i >= 2) ? 2 : 0;
  endfunction
  function automatic int stop_of(int i);
    return (i == 1) ? 32 : (i == 2) ? 24 : 16;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_transmitter #(
      .DATA_BITS(DB), .TICKS_PER_BIT(TPB),
      .STOP_BIT_TICKS(stop_of(g)), .PARITY(par_of(g))
    ) dut (
      .Clock(clk), .Reset(rst), .Tick(tick), .TxStart(start[g]),
      .TxData(data[g][DB-1:0]), .Tx(tx[g]), .TxBusy(busy[g]), .TxDone(done[g])
    );
  end

  always #5 clk = ~clk;

  // Tick every 4th clock, changed well away from the sampling edges.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      tick = tick_en && (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Reference line level at tick k of a frame carrying byte b.
  function automatic bit exp_bit(int i, logic [7:0] b, int k);
    int idx, db;
    idx = k / TPB;
    db  = db_of(i);
    if (idx == 0) return 1'b0;
    if (idx <= db) return b[idx-1];
    if (par_of(i) != 0 && idx == db + 1) return (^b) ^ (par_of(i) == 2);
    return 1'b1;
  endfunction

  task automatic check_frame(int i);
    logic [7:0] b, rx;
    int len, bad;
    tests_m++;
    if (exp_q[i].size() == 0) begin
      fails_m++;
      $display("FAIL unexpected_frame dut%0d: TxDone with no frame outstanding", i);
    end else begin
      b   = exp_q[i].pop_front();
      len = (1 + db_of(i) + (par_of(i) != 0 ? 1 : 0)) * TPB + stop_of(i);
      if (samp[i].size() != len) begin
        fails_m++;
        $display("FAIL frame_len dut%0d: got %0d ticks want %0d", i, samp[i].size(), len);
      end else begin
        bad = -1;
        for (int k = len - 1; k >= 0; k--)
          if (samp[i][k] != exp_bit(i, b, k)) bad = k;
        tests_m++;
        if (bad >= 0) begin
          fails_m++;
          $display("FAIL frame_bits dut%0d byte %h: tick %0d got %0b want %0b",
                   i, b, bad, samp[i][bad], exp_bit(i, b, bad));
        end
        rx = '0;
        for (int j = 0; j < db_of(i); j++) rx[j] = samp[i][TPB*(j+1) + TPB/2];
        tests_m++;
        if (rx != b) begin
          fails_m++;
          $display("FAIL rx_byte dut%0d: got %h want %h", i, rx, b);
        end
      end
    end
    samp[i].delete();
  endtask

  // Monitor: records the line on every counted tick, scores a frame on TxDone.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          samp[i].delete();
          prev_done[i] = 1'b0;
        end else begin
          if (busy[i] && tick) samp[i].push_back(tx[i]);
          if (done[i]) begin
            done_cnt[i]++;
            tests_m++;
            if (prev_done[i] || busy[i]) begin
              fails_m++;
              $display("FAIL done_pulse dut%0d: prev_done %0b busy %0b want 0 0",
                       i, prev_done[i], busy[i]);
            end
            check_frame(i);
          end
          prev_done[i] = done[i];
        end
      end
    end
  end

  task automatic chk(string name, int got, int want);
    tests_a++;
    if (got != want) begin
      fails_a++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[i] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy[i]) chk("idle_timeout", 1, 0);
  endtask

  task automatic send(int i, logic [7:0] b);
    wait_idle(i);
    start[i] = 1'b1;
    data[i]  = b;
    @(posedge clk);
    exp_q[i].push_back(b & 8'((1 << db_of(i)) - 1));
    sent[i]++;
    #1;
    start[i] = 1'b0;
    data[i]  = 8'($urandom);
  endtask

  initial begin
    int n, changed;
    logic t0;
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      done_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("reset_tx", tx[i], 1);
      chk("reset_busy", busy[i], 0);
      chk("reset_done", done[i], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Abort a frame during its start bit with an asynchronous reset.
    send(0, 8'h81);
    repeat (20) @(negedge clk);
    chk("start_bit_tx", tx[0], 0);
    chk("start_bit_busy", busy[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx[0], 1);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_done", done[0], 0);
    exp_q[0].delete();
    sent[0]--;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(0, 8'h55);
    send(1, 8'hA5);
    send(2, 8'hA5);
    send(3, 8'h2D);

    // Mid-frame request with different data must be ignored.
    send(0, 8'h3C);
    repeat (200) @(negedge clk);
    start[0] = 1'b1;
    data[0]  = 8'hFF;
    @(negedge clk);
    start[0] = 1'b0;

    // TxStart held: second frame accepted in the TxDone cycle.
    wait_idle(0);
    start[0] = 1'b1;
    data[0]  = 8'h0F;
    @(posedge clk);
    exp_q[0].push_back(8'h0F);
    sent[0]++;
    #1 data[0] = 8'hF0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[0] && n < 2000);
    chk("b2b_done_seen", done[0], 1);
    chk("b2b_gap_busy", busy[0], 0);
    @(posedge clk);
    exp_q[0].push_back(8'hF0);
    sent[0]++;
    #1 start[0] = 1'b0;
    @(negedge clk);
    chk("b2b_busy_again", busy[0], 1);

    // Freeze ticks mid-DATA on the 2-stop-bit instance.
    send(1, 8'($urandom));
    repeat (200) @(negedge clk);
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    t0 = tx[1];
    changed = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx[1] !== t0) changed = 1;
    end
    chk("freeze_tx", changed, 0);
    chk("freeze_busy", busy[1], 1);
    tick_en = 1'b1;

    for (int r = 0; r < 6; r++)
      for (int i = 0; i < N; i++) begin
        send(i, 8'($urandom));
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end

    for (int i = 0; i < N; i++) wait_idle(i);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("done_count", done_cnt[i], sent[i]);
      chk("queue_drained", exp_q[i].size(), 0);
    end

    tests_a += tests_m;
    fails_a += fails_m;
    $display("[TB] %0d tests run, %0d failed", tests_a, fails_a);
    $finish;
  end

endmodule
